// File: rtl/qpu_pkg.sv
// ---------------------------------------------------------------------------
// qpu_pkg
// Shared definitions for the QPU instruction sequencer:
//   - QPU_INSTR_W    : default instruction width
//   - OP_*           : 4-bit opcodes carried in the top nibble of a word
//   - fetch_state_e  : sequencer FSM states
// ---------------------------------------------------------------------------
package qpu_pkg;

  localparam int QPU_INSTR_W = 8;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_H    = 4'h1;
  localparam logic [3:0] OP_X    = 4'h2;
  localparam logic [3:0] OP_Z    = 4'h3;
  localparam logic [3:0] OP_CNOT = 4'h4;
  localparam logic [3:0] OP_MEAS = 4'h5;
  localparam logic [3:0] OP_JMP  = 4'hE;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/qpu_prog_mem.sv
// ---------------------------------------------------------------------------
// qpu_prog_mem
// DEPTH x INSTR_W program store. Synchronous write, combinational read.
// Contents are deliberately not reset so a program survives a sequencer reset.
// Ports:
//   clk      in  clock, rising edge
//   wr_en    in  write strobe
//   wr_addr  in  write address
//   wr_data  in  write data
//   rd_addr  in  read address
//   rd_data  out read data (combinational)
// ---------------------------------------------------------------------------
module qpu_prog_mem #(
  parameter int INSTR_W = 8,
  parameter int DEPTH   = 16,
  parameter int AW      = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               wr_en,
  input  logic [AW-1:0]      wr_addr,
  input  logic [INSTR_W-1:0] wr_data,
  input  logic [AW-1:0]      rd_addr,
  output logic [INSTR_W-1:0] rd_data
);

  logic [INSTR_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/qpu_instr_fetch.sv
// ---------------------------------------------------------------------------
// qpu_instr_fetch
// Instruction sequencer feeding the QPU gate executor. A program is loaded
// into qpu_prog_mem while idle; a start pulse streams it out in PC order over
// a valid/ready handshake until a HALT word or the last memory entry.
//
// Optional feature macro: QPU_FETCH_LOOP_EN
//   When defined, opcode JMP is consumed internally (pc <= operand, one bubble)
//   and the jmp_count output (saturating count of taken jumps) is present.
//
// Ports:
//   clk          in  clock, rising edge
//   reset        in  asynchronous active-high reset
//   ld_en        in  program write strobe (honoured in IDLE/DONE only)
//   ld_addr      in  program write address
//   ld_data      in  program write data
//   start        in  single-cycle start pulse (IDLE/DONE only)
//   instr        out instruction to executor
//   instr_valid  out instr is valid
//   instr_ready  in  executor accepts instr this cycle
//   pc           out address of next word to read
//   busy         out high while running
//   done         out sticky completion flag
//   jmp_count    out taken-jump count (QPU_FETCH_LOOP_EN only)
// ---------------------------------------------------------------------------
module qpu_instr_fetch
  import qpu_pkg::*;
#(
  parameter int INSTR_W = QPU_INSTR_W,
  parameter int DEPTH   = 16,
  parameter int AW      = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ld_en,
  input  logic [AW-1:0]      ld_addr,
  input  logic [INSTR_W-1:0] ld_data,
  input  logic               start,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [AW-1:0]      pc,
  output logic               busy,
`ifdef QPU_FETCH_LOOP_EN
  output logic [7:0]         jmp_count,
`endif
  output logic               done
);

  fetch_state_e       state_q, state_d;
  logic [AW-1:0]      pc_q, pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic               valid_q, valid_d;
  // Set when the word currently presented came from the last memory entry;
  // its acceptance ends the run instead of wrapping.
  logic               last_q, last_d;

  logic               mem_wr_en;
  logic [AW-1:0]      rd_addr;
  logic [INSTR_W-1:0] rd_data;
  logic [INSTR_W-1:0] fetch_word;
  logic [3:0]         fetch_op;
  logic               fetch_en;

`ifdef QPU_FETCH_LOOP_EN
  logic [7:0]         jmp_count_q, jmp_count_d;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction
`endif

  assign mem_wr_en = ld_en && (state_q != ST_RUN);

  qpu_prog_mem #(
    .INSTR_W (INSTR_W),
    .DEPTH   (DEPTH),
    .AW      (AW)
  ) u_prog_mem (
    .clk     (clk),
    .wr_en   (mem_wr_en),
    .wr_addr (ld_addr),
    .wr_data (ld_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  // A start always fetches word 0 in the same cycle so the first instruction
  // is valid one cycle later. A write landing on that word in the start
  // cycle is forwarded so the fetch sees the new data.
  assign rd_addr    = (state_q == ST_RUN) ? pc_q : '0;
  assign fetch_word = (mem_wr_en && (ld_addr == rd_addr)) ? ld_data : rd_data;
  assign fetch_op   = fetch_word[INSTR_W-1 -: 4];

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    valid_d  = valid_q;
    last_d   = last_q;
    fetch_en = 1'b0;
`ifdef QPU_FETCH_LOOP_EN
    jmp_count_d = jmp_count_q;
`endif

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d  = ST_RUN;
          pc_d     = '0;
          last_d   = 1'b0;
          fetch_en = 1'b1;
`ifdef QPU_FETCH_LOOP_EN
          jmp_count_d = 8'd0;
`endif
        end
      end
      ST_RUN: begin
        // Output register may take a new word when empty or being accepted.
        if (!valid_q || instr_ready) begin
          if (last_q) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
            state_d = ST_DONE;
          end else begin
            fetch_en = 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
      end
    endcase

    if (fetch_en) begin
      if (fetch_op == OP_HALT) begin
        // HALT is never emitted; pc stays pointing at it.
        valid_d = 1'b0;
        state_d = ST_DONE;
        pc_d    = rd_addr;
`ifdef QPU_FETCH_LOOP_EN
      end else if (fetch_op == OP_JMP) begin
        valid_d     = 1'b0;
        pc_d        = fetch_word[AW-1:0];
        jmp_count_d = sat_inc8(jmp_count_d);
`endif
      end else begin
        instr_d = fetch_word;
        valid_d = 1'b1;
        pc_d    = rd_addr + AW'(1);
        last_d  = (rd_addr == AW'(DEPTH - 1));
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      instr_q <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
`ifdef QPU_FETCH_LOOP_EN
      jmp_count_q <= 8'd0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      last_q  <= last_d;
`ifdef QPU_FETCH_LOOP_EN
      jmp_count_q <= jmp_count_d;
`endif
    end
  end

  assign instr       = instr_q;
  assign instr_valid = valid_q;
  assign pc          = pc_q;
  assign busy        = (state_q == ST_RUN);
  assign done        = (state_q == ST_DONE);
`ifdef QPU_FETCH_LOOP_EN
  assign jmp_count   = jmp_count_q;
`endif

endmodule

// File: tb/tb_qpu_instr_fetch.sv
// ---------------------------------------------------------------------------
// tb_qpu_instr_fetch
// Directed bench for qpu_instr_fetch. Inputs are driven and outputs sampled
// 1 time unit after each rising edge. Honours QPU_FETCH_LOOP_EN.
// ---------------------------------------------------------------------------
module tb_qpu_instr_fetch;

  logic       clk = 1'b0;
  logic       reset;
  logic       ld_en;
  logic [3:0] ld_addr;
  logic [7:0] ld_data;
  logic       start;
  logic [7:0] instr;
  logic       instr_valid;
  logic       instr_ready;
  logic [3:0] pc;
  logic       busy;
  logic       done;
`ifdef QPU_FETCH_LOOP_EN
  logic [7:0] jmp_count;
`endif

  int total = 0;
  int bad   = 0;

  logic [7:0] got [32];
  int         nh;

  qpu_instr_fetch dut (
    .clk         (clk),
    .reset       (reset),
    .ld_en       (ld_en),
    .ld_addr     (ld_addr),
    .ld_data     (ld_data),
    .start       (start),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .pc          (pc),
    .busy        (busy),
`ifdef QPU_FETCH_LOOP_EN
    .jmp_count   (jmp_count),
`endif
    .done        (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [3:0] a, input logic [7:0] d);
    ld_en   = 1'b1;
    ld_addr = a;
    ld_data = d;
    step();
    ld_en   = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic load_basic();
    load(4'd0, 8'h12);
    load(4'd1, 8'h21);
    load(4'd2, 8'h34);
    load(4'd3, 8'hF0);
  endtask

  // Runs until done (caller already pulsed start), recording every handshake.
  // With stall=1 ready follows 1,0,0,1,... and a stalled word must hold.
  task automatic run_collect(input int budget, input bit stall);
    logic       prev_stalled;
    logic [7:0] prev_instr;
    bit         finished;
    logic [3:0] pat;
    pat          = 4'b1001;
    prev_stalled = 1'b0;
    prev_instr   = 8'h00;
    finished     = 1'b0;
    nh           = 0;
    for (int i = 0; i < budget; i++) begin
      instr_ready = stall ? pat[i % 4] : 1'b1;
      if (prev_stalled) chk("hold_stable", {instr_valid, instr}, {1'b1, prev_instr});
      if (instr_valid && instr_ready && nh < 32) begin
        got[nh] = instr;
        nh++;
      end
      prev_stalled = instr_valid && !instr_ready;
      prev_instr   = instr;
      if (done) begin
        finished = 1'b1;
        break;
      end
      step();
    end
    if (!finished) chk("run_timeout", {31'd0, done}, 32'd1);
    instr_ready = 1'b1;
  endtask

  initial begin
    reset       = 1'b1;
    ld_en       = 1'b0;
    ld_addr     = 4'd0;
    ld_data     = 8'h00;
    start       = 1'b0;
    instr_ready = 1'b1;
    step();
    step();
    chk("rst_instr", {24'd0, instr}, 32'h0);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_pc", {28'd0, pc}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    reset = 1'b0;
    step();

    // Basic program, ready held high.
    load_basic();
    pulse_start();
    chk("t1_c1", {busy, instr_valid, instr}, {1'b1, 1'b1, 8'h12});
    chk("t1_c1_pc", {28'd0, pc}, 32'd1);
    step();
    chk("t1_c2", {instr_valid, instr}, {1'b1, 8'h21});
    step();
    chk("t1_c3", {instr_valid, instr}, {1'b1, 8'h34});
    step();
    chk("t1_c4", {done, busy, instr_valid}, {1'b1, 1'b0, 1'b0});
    chk("t1_pc_done", {28'd0, pc}, 32'd3);
    step();
    step();
    chk("t1_done_sticky", {31'd0, done}, 32'd1);

    // Same program with a stalling executor.
    pulse_start();
    chk("t2_done_clr", {31'd0, done}, 32'd0);
    run_collect(60, 1'b1);
    chk("t2_count", nh, 32'd3);
    chk("t2_w0", {24'd0, got[0]}, 32'h12);
    chk("t2_w1", {24'd0, got[1]}, 32'h21);
    chk("t2_w2", {24'd0, got[2]}, 32'h34);

    // Full memory without HALT: 16 transfers, no wrap-around re-run.
    for (int a = 0; a < 16; a++) load(4'(a), 8'h10);
    pulse_start();
    run_collect(60, 1'b0);
    chk("t3_count", nh, 32'd16);
    chk("t3_done", {31'd0, done}, 32'd1);
    chk("t3_pc", {28'd0, pc}, 32'd0);
    step();
    chk("t3_no17", {31'd0, instr_valid}, 32'd0);

    // Reset mid-stream after two transfers.
    load_basic();
    pulse_start();
    step();
    step();
    chk("t4_pre", {instr_valid, instr}, {1'b1, 8'h34});
    reset = 1'b1;
    #1;
    chk("t4_async", {instr_valid, busy, pc}, {1'b0, 1'b0, 4'd0});
    step();
    reset = 1'b0;
    step();
    chk("t4_idle", {done, busy}, {1'b0, 1'b0});
    pulse_start();
    chk("t4_replay", {instr_valid, instr}, {1'b1, 8'h12});
    run_collect(20, 1'b0);

    // start and ld_en during RUN are ignored.
    pulse_start();
    chk("t5_first", {24'd0, instr}, 32'h12);
    start   = 1'b1;
    ld_en   = 1'b1;
    ld_addr = 4'd0;
    ld_data = 8'h55;
    step();
    start   = 1'b0;
    ld_en   = 1'b0;
    chk("t5_no_restart", {instr_valid, instr}, {1'b1, 8'h21});
    run_collect(20, 1'b0);
    chk("t5_done", {31'd0, done}, 32'd1);
    pulse_start();
    chk("t5_rerun", {instr_valid, instr}, {1'b1, 8'h12});
    run_collect(20, 1'b0);

    // Write and start in the same cycle: fetch sees the new word.
    ld_en   = 1'b1;
    ld_addr = 4'd0;
    ld_data = 8'h33;
    start   = 1'b1;
    step();
    ld_en   = 1'b0;
    start   = 1'b0;
    chk("t6_bypass", {instr_valid, instr}, {1'b1, 8'h33});
    run_collect(20, 1'b0);
    load(4'd0, 8'h12);

    // JMP program {11, E0, F0}.
    load(4'd0, 8'h11);
    load(4'd1, 8'hE0);
    load(4'd2, 8'hF0);
`ifdef QPU_FETCH_LOOP_EN
    pulse_start();
    chk("t7_w0", {instr_valid, instr}, {1'b1, 8'h11});
    chk("t7_jc0", {24'd0, jmp_count}, 32'd0);
    step();
    chk("t7_bubble", {instr_valid, pc}, {1'b0, 4'd0});
    chk("t7_jc1", {24'd0, jmp_count}, 32'd1);
    step();
    chk("t7_again", {instr_valid, instr}, {1'b1, 8'h11});
    step();
    chk("t7_jc2", {24'd0, jmp_count}, 32'd2);
    for (int i = 0; i < 600; i++) step();
    chk("t7_sat", {24'd0, jmp_count}, 32'd255);
    chk("t7_busy", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    chk("t7_jc_rst", {24'd0, jmp_count}, 32'd0);
`else
    pulse_start();
    chk("t7_w0", {instr_valid, instr}, {1'b1, 8'h11});
    step();
    chk("t7_w1", {instr_valid, instr}, {1'b1, 8'hE0});
    step();
    chk("t7_done", {done, instr_valid}, {1'b1, 1'b0});
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/qpu_instr_fetch.md
Name: qpu_instr_fetch

Overview:
- Instruction sequencer sitting directly upstream of the QPU gate-execution datapath inside top.
- Holds a small program memory, loaded over a write port while idle. On a start pulse it streams instructions in PC order to the executor over a valid/ready handshake.
- Stops on HALT or at end of memory and flags done.
- The bench's "run N instructions after reset" flow becomes load → start → wait for done.

Parameters:
- INSTR_W, 8, instruction width: opcode = [INSTR_W-1:INSTR_W-4], operand = remaining low bits.
- DEPTH, 16, program memory entries; must be a power of 2.
- AW, $clog2(DEPTH), address/PC width.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- ld_en  in  1  program-memory write strobe; honoured only in IDLE or DONE.
- ld_addr  in  AW  write address.
- ld_data  in  INSTR_W  write data.
- start  in  1  single-cycle pulse; begins execution at PC 0.
- instr  out  INSTR_W  instruction presented to the executor.
- instr_valid  out  1  instr is valid.
- instr_ready  in  1  executor accepts instr this cycle.
- pc  out  AW  address of the next memory word to be read.
- busy  out  1  high in RUN.
- done  out  1  high in DONE; sticky until the next start or reset.

Behaviour:
- Reset (async assert, sync release):
  - Outputs: instr=0, instr_valid=0, pc=0, busy=0, done=0; state=IDLE.
  - Program memory is NOT reset; it keeps its contents.
- States: IDLE, RUN, DONE.
- IDLE:
  - ld_en writes mem[ld_addr].
  - start → RUN with pc=0, busy=1.
- RUN, load condition: the output register loads when (!instr_valid || instr_ready).
- RUN, on load, with w = mem[pc]:
  - w opcode == HALT (4'hF): instr_valid←0, w not emitted, state→DONE.
  - Otherwise: instr←w, instr_valid←1, pc←pc+1.
  - If pc was DEPTH-1 and w was not HALT: emit w, then on its acceptance go to DONE. No wrap.
- RUN, no load (valid && !ready): instr, instr_valid and pc hold unchanged. Never drop or duplicate an instruction.
- Timing:
  - First instr_valid appears exactly 1 cycle after the start cycle.
  - Sustained throughput is 1 instruction/cycle while instr_ready=1.
- DONE:
  - done=1, busy=0, instr_valid=0.
  - ld_en is allowed.
  - start → RUN from pc=0 and clears done.
- Ignored inputs:
  - start during RUN is ignored.
  - ld_en during RUN is ignored; memory is unchanged.
- Simultaneous ld_en and start in IDLE: the write happens first, and the first fetch sees the new data.
- Reset during RUN aborts immediately. Any in-flight instr is dropped (instr_valid=0).

Optional Feature:
- Macro: QPU_FETCH_LOOP_EN.
- Defined:
  - Opcode 4'hE (JMP) is consumed internally; it is never emitted.
  - Action: pc←operand[AW-1:0], zero-extended.
  - Costs one bubble cycle: instr_valid=0 for that load slot.
  - A JMP at pc DEPTH-1 is still taken.
  - Adds output jmp_count (8 bits, saturating at 255). It counts taken jumps, resets to 0 on reset and on start, and exists only when the macro is defined.
- Undefined: 4'hE is an ordinary instruction and is emitted unchanged; the jmp_count port does not exist.

Decomposition:
- Package qpu_pkg:
  - opcode localparams: OP_NOP=4'h0, OP_H=4'h1, OP_X=4'h2, OP_Z=4'h3, OP_CNOT=4'h4, OP_MEAS=4'h5, OP_JMP=4'hE, OP_HALT=4'hF.
  - fetch state enum.
  - INSTR_W default.
- Sub-module: qpu_prog_mem (DEPTH×INSTR_W register array; synchronous write, combinational read), instantiated once.
- The FSM and output register stay in qpu_instr_fetch.

Test Plan:
- Load mem = {12, 21, 34, F0}, start, instr_ready=1:
  - instr_valid on cycles +1..+3 with instr 8'h12, 8'h21, 8'h34.
  - done=1 on cycle +4.
  - pc=3 at done.
- Same program, instr_ready toggling 1,0,0,1,…: each instr is held stable while stalled; exactly 3 handshakes occur, in order, with no duplicates.
- Fill all 16 entries with 8'h10 (no HALT), ready=1: 16 transfers, then done=1 with pc wrapped to 0 and no 17th valid.
- Assert reset for one cycle mid-stream after 2 transfers:
  - Immediately: instr_valid=0, busy=0, pc=0.
  - Memory is intact; a new start replays from 8'h12.
- start during RUN and ld_en to address 0 during RUN are both ignored; a re-run after done still emits 8'h12 first.
- With QPU_FETCH_LOOP_EN defined, mem = {11, E0, …}:
  - Emits 8'h11, one bubble, then 8'h11 again.
  - jmp_count increments to 1, 2, …, saturating at 255.
  - Without the macro, the same program emits 8'h11 then 8'hE0.
